mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and single-port memory
// signals of mem_arbiter. The master side is the pipeline plus memory; the
// slave side is the arbiter itself.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_ready;
  logic             if_stall;

  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic [WIDTH-1:0] dm_rdata;
  logic             dm_ready;
  logic             dm_stall;

  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the data port. One transaction at a time; request-to-ready latency
// is MEM_LATENCY+1 cycles with one IDLE cycle between transactions.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests (default build gives the data port fixed priority).
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [WIDTH-1:0]   r_mem_addr;
  logic [WIDTH-1:0]   r_mem_wdata;
  logic               r_if_ready;
  logic               r_dm_ready;
  logic [WIDTH-1:0]   r_if_rdata;
  logic [WIDTH-1:0]   r_dm_rdata;
  logic               w_grant_dm;
  logic               w_grant_if;

  // Arbitration of the requests seen in IDLE
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic               r_prio_if;
  assign w_grant_dm = bus.dm_req & ~(bus.if_req & r_prio_if);
`else
  assign w_grant_dm = bus.dm_req;
`endif
  assign w_grant_if = bus.if_req & ~w_grant_dm;

  // Transaction FSM: grant, single-cycle issue, latency countdown, ready pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_prio_if   <= 1'b0;
`endif
    end else begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      // Read data is only visible live during the ready cycle; keep it after
      if (r_if_ready) r_if_rdata <= bus.mem_rdata;
      if (r_dm_ready && !r_we) r_dm_rdata <= bus.mem_rdata;
      case (r_state)
        IDLE: begin
          if (w_grant_dm || w_grant_if) begin
            r_state     <= w_grant_dm ? BUSY_DM : BUSY_IF;
            r_cnt       <= LAT_LOAD;
            r_we        <= w_grant_dm & bus.dm_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_grant_dm & bus.dm_we;
            r_mem_addr  <= w_grant_dm ? bus.dm_addr : bus.if_addr;
            r_mem_wdata <= w_grant_dm ? bus.dm_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Only a contended grant moves the priority flag
            if (bus.if_req && bus.dm_req) r_prio_if <= w_grant_dm;
`endif
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (r_cnt == CNT_W'(0)) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              if (r_state == BUSY_IF) r_if_ready <= 1'b1;
              else                    r_dm_ready <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.dm_ready  = r_dm_ready;
  // Completion cycle forwards memory data; otherwise the held value
  assign bus.if_rdata  = r_if_ready ? bus.mem_rdata : r_if_rdata;
  assign bus.dm_rdata  = (r_dm_ready && !r_we) ? bus.mem_rdata : r_dm_rdata;
  assign bus.if_stall  = bus.if_req & ~r_if_ready;
  assign bus.dm_stall  = bus.dm_req & ~r_dm_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters, all checked
// every cycle against a transaction-level model of the arbiter and memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned W = 32;
  localparam int unsigned L = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(W)) bus();
  mem_arbiter #(.WIDTH(W), .MEM_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  bit chk_en = 1'b0;

  // Stimulus for the upcoming cycle
  logic         d_rst, d_if_req, d_dm_req, d_dm_we;
  logic [W-1:0] d_if_addr, d_dm_addr, d_dm_wdata, next_mem_data;

  // Transaction-level model: one outstanding transaction, cycle stamps
  int           m_issue_at = -1, m_ready_at = -1, m_free_at = 0;
  bit           m_dm, m_we, m_prio_if;
  logic [W-1:0] m_addr, m_wdata, m_data;
  logic [W-1:0] e_if_rdata = '0, e_dm_rdata = '0;
  bit           done_if, done_dm, if_act, dm_act;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, n, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, W'(act), W'(exp));
  endtask

  // One clock cycle: apply stimulus, compare, advance the model
  task automatic step();
    bit e_ifr, e_dmr, g_dm;
    @(posedge clk); #1;
    rst           = d_rst;
    bus.if_req    = d_if_req;
    bus.if_addr   = d_if_addr;
    bus.dm_req    = d_dm_req;
    bus.dm_we     = d_dm_we;
    bus.dm_addr   = d_dm_addr;
    bus.dm_wdata  = d_dm_wdata;
    bus.mem_rdata = (m_issue_at >= 0 && n == m_issue_at + int'(L)) ? m_data : W'($urandom);
    @(negedge clk);
    e_ifr = (n == m_ready_at) && !m_dm;
    e_dmr = (n == m_ready_at) && m_dm;
    if (chk_en) begin
      chk1("mem_en", bus.mem_en, n == m_issue_at);
      if (n == m_issue_at) begin
        chk1("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk1("if_ready", bus.if_ready, e_ifr);
      chk1("dm_ready", bus.dm_ready, e_dmr);
      chk("if_rdata", bus.if_rdata, e_ifr ? m_data : e_if_rdata);
      chk("dm_rdata", bus.dm_rdata, (e_dmr && !m_we) ? m_data : e_dm_rdata);
      chk1("if_stall", bus.if_stall, d_if_req && !e_ifr);
      chk1("dm_stall", bus.dm_stall, d_dm_req && !e_dmr);
    end
    if (n == m_ready_at) begin
      if (m_dm) begin
        done_dm = 1'b1;
        if (!m_we) e_dm_rdata = m_data;
      end else begin
        done_if = 1'b1;
        e_if_rdata = m_data;
      end
    end
    if (!d_rst) begin
      m_issue_at = -1; m_ready_at = -1; m_free_at = n + 1;
      e_if_rdata = '0; e_dm_rdata = '0; m_prio_if = 1'b0;
    end else if (n >= m_free_at && (d_if_req || d_dm_req)) begin
      g_dm = d_dm_req && !(d_if_req && m_prio_if);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (d_if_req && d_dm_req) m_prio_if = g_dm;
`endif
      m_dm       = g_dm;
      m_we       = g_dm && d_dm_we;
      m_addr     = g_dm ? d_dm_addr : d_if_addr;
      m_wdata    = d_dm_wdata;
      m_data     = next_mem_data;
      m_issue_at = n + 1;
      m_ready_at = n + 1 + int'(L);
      m_free_at  = n + int'(L) + 2;
    end
    n++;
  endtask

  // Randomized requesters obeying the hold-until-ready protocol
  task automatic drive_random();
    bit if_fly, dm_fly;
    d_rst = ($urandom_range(0, 59) != 0);
    next_mem_data = W'($urandom);
    if_fly = (m_issue_at >= 0) && !m_dm && m_issue_at <= n && m_ready_at >= n;
    dm_fly = (m_issue_at >= 0) &&  m_dm && m_issue_at <= n && m_ready_at >= n;
    if (done_if || (if_act && !d_if_req && !if_fly)) begin if_act = 1'b0; done_if = 1'b0; end
    if (done_dm || (dm_act && !d_dm_req && !dm_fly)) begin dm_act = 1'b0; done_dm = 1'b0; end
    if (!if_act) begin
      d_if_addr = W'($urandom);
      if_act    = ($urandom_range(0, 2) == 0);
      d_if_req  = if_act;
    end else if (if_fly && m_ready_at > n && $urandom_range(0, 7) == 0) begin
      d_if_req = 1'b0;
    end
    if (!dm_act) begin
      d_dm_addr  = W'($urandom);
      d_dm_wdata = W'($urandom);
      d_dm_we    = $urandom_range(0, 1) == 1;
      dm_act     = ($urandom_range(0, 2) == 0);
      d_dm_req   = dm_act;
    end else if (dm_fly && m_ready_at > n && $urandom_range(0, 7) == 0) begin
      d_dm_req = 1'b0;
    end
  endtask

  initial begin
    int t0;
    d_rst = 1'b0; d_if_req = 1'b0; d_dm_req = 1'b0; d_dm_we = 1'b0;
    d_if_addr = '0; d_dm_addr = '0; d_dm_wdata = '0; next_mem_data = '0;
    step();
    chk_en = 1'b1;
    step();
    chk1("lit_rst_mem_en", bus.mem_en, 1'b0);
    chk("lit_rst_if_rdata", bus.if_rdata, '0);
    chk("lit_rst_mem_addr", bus.mem_addr, '0);
    d_rst = 1'b1;
    step();

    // Fetch read
    d_if_req = 1'b1; d_if_addr = 32'h10; next_mem_data = 32'hDEADBEEF; t0 = n;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) chk("lit_model_latency", W'(m_ready_at - t0), W'(L + 1));
      if (k == 1) begin chk1("lit_f_mem_en", bus.mem_en, 1'b1); chk("lit_f_addr", bus.mem_addr, 32'h10); end
      if (k == 3) begin
        chk1("lit_f_ready", bus.if_ready, 1'b1); chk("lit_f_rdata", bus.if_rdata, 32'hDEADBEEF);
        d_if_req = 1'b0;
      end
      if (k == 4) chk("lit_f_hold", bus.if_rdata, 32'hDEADBEEF);
    end

    // Data write
    d_dm_req = 1'b1; d_dm_we = 1'b1; d_dm_addr = 32'h40; d_dm_wdata = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) begin
        chk1("lit_w_we", bus.mem_we, 1'b1); chk("lit_w_addr", bus.mem_addr, 32'h40);
        chk("lit_w_wdata", bus.mem_wdata, 32'h12345678);
      end
      if (k == 3) begin
        chk1("lit_w_ready", bus.dm_ready, 1'b1); chk("lit_w_rdata", bus.dm_rdata, '0);
        d_dm_req = 1'b0;
      end
    end

    // Simultaneous requests: data port first, fetch after one IDLE cycle
    d_if_req = 1'b1; d_if_addr = 32'h20;
    d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h80; next_mem_data = 32'hA5A50001;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 0) next_mem_data = 32'h0BADF00D;
      if (k == 1) chk("lit_c_dm_addr", bus.mem_addr, 32'h80);
      if (k == 3) begin
        chk1("lit_c_dm_ready", bus.dm_ready, 1'b1); chk("lit_c_dm_rdata", bus.dm_rdata, 32'hA5A50001);
        d_dm_req = 1'b0;
      end
      if (k == 5) begin chk1("lit_c_if_en", bus.mem_en, 1'b1); chk("lit_c_if_addr", bus.mem_addr, 32'h20); end
      if (k == 7) begin
        chk1("lit_c_if_ready", bus.if_ready, 1'b1); chk("lit_c_if_rdata", bus.if_rdata, 32'h0BADF00D);
        d_if_req = 1'b0;
      end
    end

    // Held data read: stall until ready
    d_dm_req = 1'b1; d_dm_we = 1'b0; d_dm_addr = 32'h44; next_mem_data = 32'h5555AAAA;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k <= 2) chk1("lit_s_stall", bus.dm_stall, 1'b1);
      if (k == 3) begin
        chk1("lit_s_stall_rdy", bus.dm_stall, 1'b0); chk("lit_s_rdata", bus.dm_rdata, 32'h5555AAAA);
        d_dm_req = 1'b0;
      end
    end

    // Request dropped mid-transaction still completes
    d_dm_req = 1'b1; d_dm_we = 1'b1; d_dm_addr = 32'h48; d_dm_wdata = 32'h77;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) d_dm_req = 1'b0;
      if (k == 3) begin
        chk1("lit_d_ready", bus.dm_ready, 1'b1); chk("lit_d_rdata", bus.dm_rdata, 32'h5555AAAA);
      end
    end

    // Reset in the middle of a fetch, then the held request completes
    d_if_req = 1'b1; d_if_addr = 32'h30; next_mem_data = 32'h11111111;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 1) d_rst = 1'b0;
      if (k == 2) begin d_rst = 1'b1; next_mem_data = 32'hCAFE0003; end
      if (k == 3) begin
        chk1("lit_r_ready", bus.if_ready, 1'b0); chk1("lit_r_en", bus.mem_en, 1'b0);
        chk("lit_r_if_rdata", bus.if_rdata, '0); chk("lit_r_dm_rdata", bus.dm_rdata, '0);
      end
      if (k == 4) chk("lit_r_addr", bus.mem_addr, 32'h30);
      if (k == 6) begin
        chk1("lit_r_ready2", bus.if_ready, 1'b1); chk("lit_r_rdata2", bus.if_rdata, 32'hCAFE0003);
        d_if_req = 1'b0;
      end
    end

    // Randomized traffic
    done_if = 1'b0; done_dm = 1'b0; if_act = 1'b0; dm_act = 1'b0;
    repeat (4000) begin
      drive_random();
      step();
    end
    d_rst = 1'b1; d_if_req = 1'b0; d_dm_req = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
